counter_sram_reader: RTL
========================

# counter_sram_reader

Bus-side reader for the counter sample buffer. Holds the read pointer of the ring buffer that the counter fills through SRAM port A. Drains samples through SRAM port B in response to system-bus reads, and reports fill level and overflow so software can empty the buffer while acquisition keeps running.

## Interface
Parameters:
- ADDR_WIDTH, 12, SRAM address width.
- DATA_WIDTH, 18, sample width; must be ≤ 31.
- DEPTH, 4096, buffer depth; must equal 2**ADDR_WIDTH.

Ports:
- i_clk  in  1  single clock for the whole block.
- i_rstn  in  1  reset: synchronous, active-low.
- i_wr_ptr  in  ADDR_WIDTH+1  counter-side write pointer (words written, free-running with wrap bit); advances at most 1 per cycle, only after the word is in the SRAM.
- i_clear  in  1  hardware flush pulse from the counter (acquisition restart).
- o_sram_addr  out  ADDR_WIDTH  SRAM port B address (port B never writes).
- i_sram_data  in  DATA_WIDTH  SRAM port B read data, one-cycle registered latency.
- i_bus_addr  in  8  byte offset within the block.
- i_bus_wdata  in  32  write data.
- i_bus_wen  in  1  write strobe, single-cycle pulse.
- i_bus_ren  in  1  read strobe, single-cycle pulse.
- o_bus_rdata  out  32  read data, valid while o_bus_ack = 1.
- o_bus_ack  out  1  one-cycle acknowledge.
- o_bus_err  out  1  error flag, valid with o_bus_ack.
- o_empty  out  1  fill level is 0.
- o_overflow  out  1  sticky overflow.

## Operation
- Registers:
  - rd_ptr (ADDR_WIDTH+1).
  - wr_q: i_wr_ptr registered once.
  - fill = (wr_q − rd_ptr) mod 2**(ADDR_WIDTH+1).
- o_sram_addr = rd_ptr[ADDR_WIDTH-1:0], driven from the register with no combinational bus path.
- Register map:
  - 0x00 STATUS (R): [15:0] fill, [16] overflow, [17] empty.
  - 0x04 DATA (R): pop. Returns [DATA_WIDTH-1:0] sample, [31] valid, other bits 0.
  - 0x08 CONTROL (W): bit0 = 1 flushes (rd_ptr ← wr_q) and clears overflow; other bits ignored.
  - 0x0C RD_PTR (R): rd_ptr zero-extended.
  - Any other offset, or a write to a read-only offset: ack with err = 1 and rdata = 0.
- FSM states:
  - IDLE: accept a request.
    - DATA read with fill ≠ 0 → WAIT.
    - DATA read with fill = 0 → immediate response rdata = 0 (valid = 0), err = 0.
    - Any other request → immediate response.
  - WAIT: one cycle for the SRAM. Then capture i_sram_data, assert ack, rd_ptr += 1, return to IDLE.
- Only one request is outstanding at a time. Strobes seen while in WAIT are ignored. If wen and ren arrive in the same cycle, the write is served and the read is dropped.
- Overflow is checked every cycle. fill > DEPTH → overflow ← 1 and rd_ptr ← wr_q (flush); this takes priority over a pop increment in the same cycle.
- i_clear has the same effect as the overflow flush but does not set overflow. The CONTROL flush also clears overflow. If a flush, overflow or i_clear coincides with a WAIT completion, the pop still acks but returns valid = 0 with data 0, and rd_ptr takes the flush value.
- Pointer wrap: rd_ptr and wr_q roll over modulo 2**(ADDR_WIDTH+1); the SRAM address wraps DEPTH−1 → 0.

## Timing
- Reset values (i_rstn sampled low at a clock edge):
  - rd_ptr = 0, wr_q = 0, FSM = IDLE.
  - o_bus_ack = 0, o_bus_err = 0, o_bus_rdata = 0, o_sram_addr = 0.
  - o_empty = 1, o_overflow = 0.
- Reset mid-request: the request is discarded and no ack is issued.
- A strobe in cycle T is served as follows:
  - STATUS, RD_PTR, CONTROL, errors and empty DATA: ack in cycle T+1.
  - Non-empty DATA: ack in cycle T+2.
- o_bus_ack is high for exactly one cycle. o_bus_rdata and o_bus_err are registered and return to 0 when ack is low.
- DATA data path:
  - SRAM output during T+1 reflects the address present at the edge ending cycle T.
  - rd_ptr increments at the edge ending T+1, so the new value is visible in T+2.
- i_wr_ptr to fill/o_empty latency: 2 cycles (wr_q register, then the flag register). A sample written in cycle N is poppable by a DATA strobe no earlier than N+2.
- o_overflow rises 2 cycles after the i_wr_ptr step that makes fill = DEPTH+1.

## Test plan
- Reset: hold i_rstn = 0 for 3 cycles, release, read STATUS → rdata 0x0002_0000 in T+1, err 0; o_empty = 1, o_sram_addr = 0.
- Basic pop: load SRAM words 0x1, 0x2, 0x3 and step i_wr_ptr to 3.
  - Three DATA reads → 0x8000_0001, 0x8000_0002, 0x8000_0003, each acked at T+2.
  - STATUS → 0x0002_0000.
  - Fourth DATA read → 0x0000_0000, acked at T+1.
- Wrap: flush with rd_ptr = 4095, wr_ptr = 4097, words at 4095 and 0 set to 0x3FFFF and 0x00005.
  - Two pops → 0x8003_FFFF, then 0x8000_0005.
  - RD_PTR → 4097.
- Overflow: rd_ptr = 0, step i_wr_ptr to 4097 → o_overflow = 1, STATUS fill = 0, RD_PTR = 4097. CONTROL write 0x1 → o_overflow = 0 one cycle later.
- Collision and errors:
  - i_clear in the WAIT cycle of a pop → ack at T+2 with rdata 0, rd_ptr = wr_q.
  - Read of 0x10 → ack at T+1, err = 1, rdata 0.
  - Write to 0x00 → err = 1.
  - Simultaneous wen (CONTROL) and ren (DATA) → only the flush happens, and one ack.

Source files
------------

// File: rtl/counter_sram_reader.sv
// Bus-side reader for the counter sample ring buffer: owns the read pointer,
// pops samples through SRAM port B and reports fill level and sticky overflow.
module counter_sram_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [ADDR_WIDTH:0]   i_wr_ptr,
    input  logic                  i_clear,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    input  logic [DATA_WIDTH-1:0] i_sram_data,
    input  logic [7:0]            i_bus_addr,
    input  logic [31:0]           i_bus_wdata,
    input  logic                  i_bus_wen,
    input  logic                  i_bus_ren,
    output logic [31:0]           o_bus_rdata,
    output logic                  o_bus_ack,
    output logic                  o_bus_err,
    output logic                  o_empty,
    output logic                  o_overflow
);

    localparam int                PTR_WIDTH   = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LVL = PTR_WIDTH'(DEPTH);

    localparam logic [7:0] OFS_STATUS  = 8'h00;
    localparam logic [7:0] OFS_DATA    = 8'h04;
    localparam logic [7:0] OFS_CONTROL = 8'h08;
    localparam logic [7:0] OFS_RD_PTR  = 8'h0C;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_WIDTH:0] rd_ptr_q;
    logic [ADDR_WIDTH:0] wr_q;
    logic [ADDR_WIDTH:0] fill;
    logic                ovf_q;
    logic                empty_q;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         sample;
    logic                pop;
    logic                ctrl_flush;
    logic                ovf_hit;
    logic                hw_flush;
    logic                unused_wdata;

    // Pointers are free-running with a wrap bit, so plain subtraction gives the level.
    assign fill     = wr_q - rd_ptr_q;
    assign ovf_hit  = fill > DEPTH_LVL;
    assign hw_flush = ovf_hit | i_clear;

    assign unused_wdata = ^i_bus_wdata[31:1];

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d    = state_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = '0;
        pop        = 1'b0;
        ctrl_flush = 1'b0;
        sample     = '0;
        sample[DATA_WIDTH-1:0] = i_sram_data;
        sample[31] = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (i_bus_wen) begin
                    ack_d = 1'b1;
                    if (i_bus_addr == OFS_CONTROL) ctrl_flush = i_bus_wdata[0];
                    else                           err_d      = 1'b1;
                end else if (i_bus_ren) begin
                    ack_d = 1'b1;
                    case (i_bus_addr)
                        OFS_STATUS: rdata_d = {14'b0, fill == '0, ovf_q, 16'(fill)};
                        OFS_DATA: begin
                            if (fill != '0) begin
                                ack_d   = 1'b0;
                                state_d = ST_WAIT;
                            end
                        end
                        OFS_RD_PTR: rdata_d = 32'(rd_ptr_q);
                        default:    err_d   = 1'b1;
                    endcase
                end
            end
            ST_WAIT: begin
                ack_d   = 1'b1;
                pop     = 1'b1;
                state_d = ST_IDLE;
                // A flush landing on the completion invalidates the sample in flight.
                rdata_d = hw_flush ? '0 : sample;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            wr_q     <= '0;
            ovf_q    <= 1'b0;
            empty_q  <= 1'b1;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= i_wr_ptr;
            empty_q <= (fill == '0);
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;

            if (ovf_hit)         ovf_q <= 1'b1;
            else if (ctrl_flush) ovf_q <= 1'b0;

            if (hw_flush || ctrl_flush) rd_ptr_q <= wr_q;
            else if (pop)               rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign o_sram_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    assign o_bus_rdata = rdata_q;
    assign o_bus_ack   = ack_q;
    assign o_bus_err   = err_q;
    assign o_empty     = empty_q;
    assign o_overflow  = ovf_q;

endmodule
